// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one bus request at a time and
// feeds decode through a registered f_* interface backed by a one-entry skid buffer.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_ok,
    input  logic [31:0] iresp_data,
    input  logic        stall,
    input  logic        branch,
    input  logic [63:0] branch_target,
    output logic        f_valid,
    output logic [63:0] f_pc,
    output logic [31:0] f_instr
);

    typedef enum logic [1:0] {
        FETCH,
        SKID,
        DROP
    } state_t;

    state_t      state;
    logic [63:0] pc;
    logic [63:0] skid_pc_p0;
    logic [31:0] skid_instr_p0;

    logic advance;
    logic redirect;
    logic resp;
    logic skid_load;

    function automatic logic [63:0] pc_incr(input logic [63:0] p);
        return p + 64'(PC_STEP);
    endfunction

    assign advance   = !stall || !f_valid;
    assign redirect  = branch && f_valid && !stall;
    assign resp      = iresp_ok && ireq_valid;
    assign skid_load = (state == FETCH) && resp && !redirect && !advance;

    // Skid stage: captures a response that arrives while decode is stalled
    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_pc_p0    <= ireq_addr;
            skid_instr_p0 <= iresp_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            ireq_valid <= 1'b0;
            ireq_addr  <= 64'd0;
            f_valid    <= 1'b0;
            f_pc       <= 64'd0;
            f_instr    <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        pc      <= branch_target;
                        f_valid <= 1'b0;
                        // An in-flight request must complete before the bus may move on
                        if (ireq_valid && !iresp_ok) begin
                            state <= DROP;
                        end else begin
                            ireq_valid <= 1'b1;
                            ireq_addr  <= branch_target;
                        end
                    end else if (resp) begin
                        pc <= pc_incr(pc);
                        if (advance) begin
                            f_valid   <= 1'b1;
                            f_pc      <= ireq_addr;
                            f_instr   <= iresp_data;
                            ireq_addr <= pc_incr(pc);
                        end else begin
                            state      <= SKID;
                            ireq_valid <= 1'b0;
                        end
                    end else begin
                        if (advance) begin
                            f_valid <= 1'b0;
                        end
                        ireq_valid <= 1'b1;
                        ireq_addr  <= pc;
                    end
                end
                SKID: begin
                    if (redirect) begin
                        pc         <= branch_target;
                        f_valid    <= 1'b0;
                        state      <= FETCH;
                        ireq_valid <= 1'b1;
                        ireq_addr  <= branch_target;
                    end else if (advance) begin
                        f_valid    <= 1'b1;
                        f_pc       <= skid_pc_p0;
                        f_instr    <= skid_instr_p0;
                        state      <= FETCH;
                        ireq_valid <= 1'b1;
                        ireq_addr  <= pc;
                    end
                end
                DROP: begin
                    f_valid <= 1'b0;
                    if (redirect) begin
                        pc <= branch_target;
                    end
                    if (resp) begin
                        state     <= FETCH;
                        ireq_addr <= redirect ? branch_target : pc;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic, checked
// against an instruction-stream model (expected next PC of the architectural flow).
module tb_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_ok;
    logic [31:0] iresp_data;
    logic        stall;
    logic        branch;
    logic [63:0] branch_target;
    logic        f_valid;
    logic [63:0] f_pc;
    logic [31:0] f_instr;

    int checks = 0;
    int errors = 0;

    // bus responder state
    bit bus_busy = 1'b0;
    int bus_cnt  = 0;
    int bus_lat  = 0;
    int bus_fixed = 0;

    // previous-cycle snapshot and stream model
    logic        p_fv, p_stall, p_taken, p_consumed, p_iv, p_ok;
    logic [63:0] p_fpc, p_target, p_addr;
    logic [31:0] p_finstr;
    logic [63:0] exp_pc;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC(RST_PC),
        .PC_STEP (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ireq_valid   (ireq_valid),
        .ireq_addr    (ireq_addr),
        .iresp_ok     (iresp_ok),
        .iresp_data   (iresp_data),
        .stall        (stall),
        .branch       (branch),
        .branch_target(branch_target),
        .f_valid      (f_valid),
        .f_pc         (f_pc),
        .f_instr      (f_instr)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic bus_drive();
        if (!reset) begin
            bus_busy   = 1'b0;
            iresp_ok   = ~iresp_ok;
            iresp_data = $urandom;
        end else if (ireq_valid) begin
            if (!bus_busy) begin
                bus_busy = 1'b1;
                bus_cnt  = 0;
                bus_lat  = (bus_fixed >= 0) ? bus_fixed : int'($urandom_range(0, 3));
            end
            iresp_ok   = (bus_cnt == bus_lat);
            iresp_data = iresp_ok ? mem_word(ireq_addr) : $urandom;
            if (iresp_ok) bus_busy = 1'b0;
            else bus_cnt++;
        end else begin
            iresp_ok   = 1'b0;
            iresp_data = $urandom;
        end
    endtask

    task automatic monitor();
        if (p_consumed) exp_pc = p_taken ? p_target : p_fpc + 64'd4;
        if (p_iv && !p_ok) begin
            check("bus_valid_stable", {63'd0, ireq_valid}, 64'd1);
            check("bus_addr_stable", ireq_addr, p_addr);
        end
        if (p_taken) check("redirect_bubble", {63'd0, f_valid}, 64'd0);
        if (p_fv && p_stall) begin
            check("hold_valid", {63'd0, f_valid}, 64'd1);
            check("hold_pc", f_pc, p_fpc);
            check("hold_instr", {32'd0, f_instr}, {32'd0, p_finstr});
        end else if (f_valid) begin
            check("stream_pc", f_pc, exp_pc);
            check("stream_instr", {32'd0, f_instr}, {32'd0, mem_word(f_pc)});
        end
    endtask

    task automatic step();
        bus_drive();
        p_fv       = f_valid;
        p_stall    = stall;
        p_taken    = branch && f_valid && !stall;
        p_consumed = f_valid && !stall;
        p_iv       = ireq_valid;
        p_ok       = iresp_ok;
        p_fpc      = f_pc;
        p_finstr   = f_instr;
        p_target   = branch_target;
        p_addr     = ireq_addr;
        @(posedge clk);
        @(negedge clk);
        if (mon_en) monitor();
    endtask

    task automatic wait_valid(input int limit);
        for (int i = 0; i < limit && !f_valid; i++) step();
        check("wait_valid", {63'd0, f_valid}, 64'd1);
    endtask

    task automatic release_reset();
        reset  = 1'b1;
        exp_pc = RST_PC;
        mon_en = 1'b1;
    endtask

    initial begin
        reset = 1'b0; iresp_ok = 1'b0; iresp_data = '0;
        stall = 1'b0; branch = 1'b0; branch_target = '0;
        @(negedge clk);
        step();
        check("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        check("rst_f_valid", {63'd0, f_valid}, 64'd0);
        check("rst_f_pc", f_pc, 64'd0);
        check("rst_f_instr", {32'd0, f_instr}, 64'd0);

        // zero-wait sequential fetch
        bus_fixed = 0;
        release_reset();
        step();
        check("seq_addr0", ireq_addr, 64'h8000_0000);
        check("seq_valid0", {63'd0, ireq_valid}, 64'd1);
        step();
        check("seq_addr1", ireq_addr, 64'h8000_0004);
        check("seq_fpc0", f_pc, 64'h8000_0000);
        step();
        check("seq_addr2", ireq_addr, 64'h8000_0008);
        check("seq_fpc1", f_pc, 64'h8000_0004);

        // stall with a response landing in the skid buffer
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_fpc", f_pc, 64'h8000_0004);
            check("stall_ireq_off", {63'd0, ireq_valid}, 64'd0);
        end
        stall = 1'b0;
        step();
        check("skid_out_pc", f_pc, 64'h8000_0008);
        step();
        check("after_skid_pc", f_pc, 64'h8000_000C);

        // redirect with a zero-wait bus
        branch = 1'b1; branch_target = 64'h8000_0100;
        step();
        branch = 1'b0;
        check("br_bubble", {63'd0, f_valid}, 64'd0);
        check("br_addr", ireq_addr, 64'h8000_0100);
        step();
        check("br_fpc", f_pc, 64'h8000_0100);

        // redirect during the first wait cycle of a slow request
        bus_fixed = 3;
        branch = 1'b1; branch_target = 64'h8000_0200;
        step();
        branch = 1'b0;
        check("drop_addr_a", ireq_addr, 64'h8000_0104);
        check("drop_fv", {63'd0, f_valid}, 64'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("drop_addr_b", ireq_addr, 64'h8000_0104);
        end
        step();
        check("drop_new_addr", ireq_addr, 64'h8000_0200);
        check("drop_fv_end", {63'd0, f_valid}, 64'd0);
        wait_valid(12);
        check("drop_target_pc", f_pc, 64'h8000_0200);

        // reset asserted while a wrong-path request is still outstanding
        branch = 1'b1; branch_target = 64'h8000_0300;
        step();
        branch = 1'b0;
        check("pre_rst_drop_addr", ireq_addr, 64'h8000_0204);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("async_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        check("async_f_valid", {63'd0, f_valid}, 64'd0);
        check("async_f_pc", f_pc, 64'd0);
        check("async_f_instr", {32'd0, f_instr}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("in_rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
            check("in_rst_f_valid", {63'd0, f_valid}, 64'd0);
        end
        bus_fixed = 0;
        release_reset();
        step();
        check("post_rst_valid", {63'd0, ireq_valid}, 64'd1);
        check("post_rst_addr", ireq_addr, RST_PC);

        // PC wrap at the top of the address space
        wait_valid(8);
        branch = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        branch = 1'b0;
        check("wrap_req", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("wrap_fpc", f_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_next_addr", ireq_addr, 64'd0);

        // random traffic against the stream model
        bus_fixed = -1;
        for (int i = 0; i < 3000; i++) begin
            stall  = ($urandom_range(0, 3) == 0);
            branch = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0:       branch_target = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 3) * 4);
                default: branch_target = {$urandom, $urandom} & ~64'h3;
            endcase
            if (i == 1500) begin
                mon_en = 1'b0;
                reset  = 1'b0;
                step();
                step();
                release_reset();
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
